// File: rtl/ship_ctrl.sv
// ship_ctrl -- player ship life-cycle controller.
//
// Tracks the ship through ALIVE -> EXPLODE -> WAIT -> INVULN -> ALIVE,
// counts lives, drives the heading phase from the steering wheel ADC and
// selects the sprite ROM frame (flame animation or explosion animation).
//
// Ports:
//   clk          system clock, all flops on the rising edge
//   reset        asynchronous, active-high reset
//   game_over    level; forces the ship into OVER (sticky until reset)
//   collision    level; ship was hit this cycle (honoured only in ALIVE)
//   accelerator  thrust button
//   wheel        steering ADC sample
//   anim_pulse   single-cycle animation tick
//   phase        registered heading phase for the sin/cos lookup
//   thrust       registered engine-on flag
//   anim_base    registered sprite ROM frame base address
//   draw_en      ship sprite visible
//   collide_en   collisions accepted this cycle (ALIVE only)
//   respawn      one-cycle pulse on entry to INVULN; mover re-centres ship
//   lives        remaining lives
//   dbg_state    current FSM state (ship_state_t encoding)
//
// Handshake: there is no valid/ready flow here. anim_pulse is a strobe that
// is acted on in exactly the cycle it is high; collision and game_over are
// levels sampled every cycle.
//
// Configuration macro: SHIP_INVULN_BLINK_EN -- when defined the sprite blinks
// once per tick during INVULN; when undefined it stays visible throughout.

module ship_ctrl #(
    parameter int WHEEL_BITS    = 12,
    parameter int SCALE         = 34,
    parameter int PHASE_BITS    = 10,
    parameter int THRUST_FRAMES = 4,
    parameter int EXPL_FRAMES   = 4,
    parameter int FRAME_SIZE    = 1020,
    parameter int EXPL_BASE     = 4080,
    parameter int ADDR_BITS     = 13,
    parameter int LIVES         = 3,
    parameter int RESPAWN_TICKS = 8,
    parameter int INVULN_TICKS  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         game_over,
    input  logic                         collision,
    input  logic                         accelerator,
    input  logic [WHEEL_BITS-1:0]        wheel,
    input  logic                         anim_pulse,
    output logic [PHASE_BITS-1:0]        phase,
    output logic                         thrust,
    output logic [ADDR_BITS-1:0]         anim_base,
    output logic                         draw_en,
    output logic                         collide_en,
    output logic                         respawn,
    output logic [$clog2(LIVES+1)-1:0]   lives,
    output logic [2:0]                   dbg_state
);

    localparam int LIVES_W = $clog2(LIVES + 1);
    localparam int MAX_T   = (EXPL_FRAMES > RESPAWN_TICKS) ?
                             ((EXPL_FRAMES > INVULN_TICKS) ? EXPL_FRAMES : INVULN_TICKS) :
                             ((RESPAWN_TICKS > INVULN_TICKS) ? RESPAWN_TICKS : INVULN_TICKS);
    localparam int CNT_W   = (MAX_T > 1) ? $clog2(MAX_T) : 1;
    localparam int FLAME_W = $clog2(THRUST_FRAMES);
    localparam int PROD_W  = WHEEL_BITS + 6;

    localparam logic [CNT_W-1:0]   EXPL_LAST    = CNT_W'(EXPL_FRAMES - 1);
    localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(RESPAWN_TICKS - 1);
    localparam logic [CNT_W-1:0]   INVULN_LAST  = CNT_W'(INVULN_TICKS - 1);
    localparam logic [FLAME_W-1:0] FLAME_LAST   = FLAME_W'(THRUST_FRAMES - 1);
    localparam logic [5:0]         SCALE_W      = 6'(SCALE);

    typedef enum logic [2:0] {
        ST_ALIVE   = 3'd0,
        ST_EXPLODE = 3'd1,
        ST_WAIT    = 3'd2,
        ST_INVULN  = 3'd3,
        ST_OVER    = 3'd4
    } ship_state_t;

    ship_state_t         state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [FLAME_W-1:0]  flame_q;
    logic [LIVES_W-1:0]  lives_q;
    logic                thrust_q;
    logic                respawn_q;
    logic [PHASE_BITS-1:0] phase_q;
    logic [ADDR_BITS-1:0]  anim_q;

    logic                tick;
    logic                hit;
    logic                counting;
    logic [PROD_W-1:0]   prod;
    logic [31:0]         anim_d;

    assign tick = anim_pulse;
    // game_over wins over a simultaneous collision, so no life is lost then.
    assign hit  = (state_q == ST_ALIVE) && collision && !game_over;
    assign counting = (state_q == ST_EXPLODE) || (state_q == ST_WAIT) ||
                      (state_q == ST_INVULN);

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ALIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        draw_en    = 1'b0;
        collide_en = 1'b0;

        if (game_over) begin
            state_d = ST_OVER;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (collision) state_d = ST_EXPLODE;
                end
                ST_EXPLODE: begin
                    // lives_q already holds the post-hit count here.
                    if (tick && cnt_q == EXPL_LAST)
                        state_d = (lives_q == '0) ? ST_OVER : ST_WAIT;
                end
                ST_WAIT: begin
                    if (tick && cnt_q == RESPAWN_LAST) state_d = ST_INVULN;
                end
                ST_INVULN: begin
                    if (tick && cnt_q == INVULN_LAST) state_d = ST_ALIVE;
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end

        case (state_q)
            ST_ALIVE: begin
                draw_en    = 1'b1;
                collide_en = 1'b1;
            end
            ST_EXPLODE: begin
                draw_en = 1'b1;
            end
            ST_INVULN: begin
`ifdef SHIP_INVULN_BLINK_EN
                // Counter is cleared on entry, so the first frame is visible.
                draw_en = ~cnt_q[0];
`else
                draw_en = 1'b1;
`endif
            end
            default: begin
                draw_en    = 1'b0;
                collide_en = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Shared tick counter for EXPLODE / WAIT / INVULN; zeroed on every
    // state change so each phase starts counting from 0.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (tick && counting) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Lives, thrust, respawn pulse
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lives_q   <= LIVES_W'(LIVES);
            thrust_q  <= 1'b0;
            respawn_q <= 1'b0;
        end else begin
            if (hit && lives_q != '0) lives_q <= lives_q - LIVES_W'(1);
            thrust_q  <= accelerator && !game_over &&
                         ((state_q == ST_ALIVE) || (state_q == ST_INVULN));
            respawn_q <= (state_q == ST_WAIT) && (state_d == ST_INVULN);
        end
    end

    // ---------------------------------------------------------------
    // Flame animation: counts down through the frames while the engine is on.
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flame_q <= '0;
        end else if (!thrust_q) begin
            flame_q <= '0;
        end else if (tick) begin
            flame_q <= (flame_q == '0) ? FLAME_LAST : flame_q - FLAME_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Sprite frame base and heading phase (both registered)
    // ---------------------------------------------------------------
    always_comb begin
        anim_d = 32'd0;
        if (state_q == ST_EXPLODE)
            anim_d = 32'(EXPL_BASE) + 32'(cnt_q) * 32'(FRAME_SIZE);
        else if (thrust_q)
            anim_d = 32'(flame_q) * 32'(FRAME_SIZE);
    end

    // Fixed-point scale: keep the PHASE_BITS just below the product's top bit.
    assign prod = PROD_W'(wheel) * PROD_W'(SCALE_W);

    logic unused_prod;
    assign unused_prod = ^{prod[PROD_W-1], prod[WHEEL_BITS+4-PHASE_BITS:0], anim_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anim_q  <= '0;
            phase_q <= '0;
        end else begin
            anim_q  <= anim_d[ADDR_BITS-1:0];
            phase_q <= (game_over || state_q == ST_OVER) ? '0 :
                       prod[WHEEL_BITS+4 -: PHASE_BITS];
        end
    end

    assign phase     = phase_q;
    assign thrust    = thrust_q;
    assign anim_base = anim_q;
    assign respawn   = respawn_q;
    assign lives     = lives_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ship_ctrl.sv
// tb_ship_ctrl -- directed self-checking bench for ship_ctrl.
// Expected values are pushed to exp_q before each step and popped when the
// matching DUT output is sampled (1 time unit after the rising edge).

module tb_ship_ctrl;

    localparam logic [2:0] S_ALIVE   = 3'd0;
    localparam logic [2:0] S_EXPLODE = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_INVULN  = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        game_over = 1'b0;
    logic        collision = 1'b0;
    logic        accelerator = 1'b0;
    logic [11:0] wheel = 12'd0;
    logic        anim_pulse = 1'b0;
    logic [9:0]  phase;
    logic        thrust;
    logic [12:0] anim_base;
    logic        draw_en;
    logic        collide_en;
    logic        respawn;
    logic [1:0]  lives;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    ship_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .game_over   (game_over),
        .collision   (collision),
        .accelerator (accelerator),
        .wheel       (wheel),
        .anim_pulse  (anim_pulse),
        .phase       (phase),
        .thrust      (thrust),
        .anim_base   (anim_base),
        .draw_en     (draw_en),
        .collide_en  (collide_en),
        .respawn     (respawn),
        .lives       (lives),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Respawn monitor, sampled mid-cycle.
    logic mon_en = 1'b0;
    int   resp_seen = 0;
    always @(negedge clk) if (mon_en && respawn) resp_seen++;

    task automatic exp_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %0d but no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else begin
                n_fail++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        anim_pulse = 1'b1;
        cycle();
        anim_pulse = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    // One full death: hit in ALIVE, explosion, and (if lives remain) the
    // WAIT / INVULN recovery back to ALIVE.
    task automatic die(input int lives_after);
        collision = 1'b1;
        exp_push(S_EXPLODE); exp_push(32'(lives_after));
        cycle();
        collision = 1'b0;
        chk("die_state_explode", 32'(dbg_state));
        chk("die_lives", 32'(lives));
        repeat (4) tick();
        if (lives_after == 0) begin
            exp_push(S_OVER);
            chk("die_state_over", 32'(dbg_state));
        end else begin
            exp_push(S_WAIT);
            chk("die_state_wait", 32'(dbg_state));
            repeat (8) tick();
            exp_push(S_INVULN);
            chk("die_state_invuln", 32'(dbg_state));
            repeat (16) tick();
            exp_push(S_ALIVE);
            chk("die_state_alive", 32'(dbg_state));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic exp_draw;

        // Reset values
        cycle(); cycle();
        reset = 1'b0;
        exp_push(S_ALIVE); chk("rst_state", 32'(dbg_state));
        exp_push(3);       chk("rst_lives", 32'(lives));
        exp_push(0);       chk("rst_phase", 32'(phase));
        exp_push(0);       chk("rst_thrust", 32'(thrust));
        exp_push(0);       chk("rst_anim", 32'(anim_base));
        exp_push(0);       chk("rst_respawn", 32'(respawn));
        exp_push(1);       chk("rst_draw", 32'(draw_en));
        exp_push(1);       chk("rst_collide", 32'(collide_en));

        // Heading phase: (0xF4*34)[16:7] = 64
        wheel = 12'hF4;
        cycle(); cycle();
        exp_push(64); chk("phase_f4", 32'(phase));
        exp_push(0);  chk("phase_thrust", 32'(thrust));
        exp_push(0);  chk("phase_anim", 32'(anim_base));

        // A second wheel value: 0xFFF*34 = 139230, [16:7] = 63 (bit 17 dropped)
        wheel = 12'hFFF;
        cycle();
        exp_push(32'((32'hFFF * 34) >> 7) & 32'h3FF); chk("phase_fff", 32'(phase));
        wheel = 12'hF4;
        cycle();

        // Thrust and flame animation
        accelerator = 1'b1;
        cycle();
        exp_push(1); chk("thrust_on", 32'(thrust));
        cycle();
        exp_push(0); chk("flame_0", 32'(anim_base));
        begin
            int flame_seq [5] = '{3060, 2040, 1020, 0, 3060};
            for (int k = 0; k < 5; k++) begin
                tick();
                cycle();
                exp_push(32'(flame_seq[k]));
                chk($sformatf("flame_%0d", k + 1), 32'(anim_base));
            end
        end
        accelerator = 1'b0;
        cycle(); cycle();
        exp_push(0); chk("thrust_off", 32'(thrust));
        exp_push(0); chk("flame_off_anim", 32'(anim_base));

        // First collision: explosion frames, WAIT, respawn
        collision = 1'b1;
        cycle();
        collision = 1'b0;
        exp_push(S_EXPLODE); chk("hit1_state", 32'(dbg_state));
        exp_push(2);         chk("hit1_lives", 32'(lives));
        exp_push(0);         chk("hit1_collide", 32'(collide_en));
        exp_push(1);         chk("hit1_draw", 32'(draw_en));
        cycle();
        exp_push(4080); chk("expl_0", 32'(anim_base));
        for (int k = 1; k < 4; k++) begin
            tick();
            cycle();
            exp_push(32'(4080 + 1020 * k));
            chk($sformatf("expl_%0d", k), 32'(anim_base));
        end
        tick();
        exp_push(S_WAIT); chk("wait_state", 32'(dbg_state));
        exp_push(0);      chk("wait_draw", 32'(draw_en));
        for (int k = 0; k < 7; k++) begin
            tick();
            exp_push(0);
            chk($sformatf("wait_respawn_%0d", k), 32'(respawn));
        end
        tick();
        exp_push(S_INVULN); chk("invuln_state", 32'(dbg_state));
        exp_push(1);        chk("respawn_pulse", 32'(respawn));
        collision = 1'b1;
        cycle();
        exp_push(0); chk("respawn_end", 32'(respawn));

        // INVULN with collision held high
        for (int i = 0; i < 16; i++) begin
`ifdef SHIP_INVULN_BLINK_EN
            exp_draw = (i % 2 == 0);
`else
            exp_draw = 1'b1;
`endif
            exp_push(32'(exp_draw)); chk($sformatf("invuln_draw_%0d", i), 32'(draw_en));
            exp_push(0);             chk($sformatf("invuln_collide_%0d", i), 32'(collide_en));
            exp_push(2);             chk($sformatf("invuln_lives_%0d", i), 32'(lives));
            tick();
        end
        collision = 1'b0;
        exp_push(S_ALIVE); chk("invuln_done", 32'(dbg_state));
        exp_push(1);       chk("alive_collide", 32'(collide_en));
        exp_push(2);       chk("alive_lives", 32'(lives));

        // Remaining lives to OVER
        die(1);
        die(0);
        cycle();
        exp_push(0); chk("over_draw", 32'(draw_en));
        exp_push(0); chk("over_phase", 32'(phase));
        exp_push(0); chk("over_collide", 32'(collide_en));
        exp_push(0); chk("over_lives", 32'(lives));

        // collision + game_over together from ALIVE
        do_reset();
        exp_push(S_ALIVE); chk("rst2_state", 32'(dbg_state));
        exp_push(3);       chk("rst2_lives", 32'(lives));
        collision = 1'b1;
        game_over = 1'b1;
        cycle();
        collision = 1'b0;
        exp_push(S_OVER); chk("go_state", 32'(dbg_state));
        exp_push(3);      chk("go_lives", 32'(lives));
        exp_push(0);      chk("go_phase", 32'(phase));
        game_over = 1'b0;
        cycle(); cycle();
        exp_push(S_OVER); chk("go_sticky", 32'(dbg_state));
        exp_push(0);      chk("go_sticky_phase", 32'(phase));

        // Reset during WAIT
        do_reset();
        collision = 1'b1;
        cycle();
        collision = 1'b0;
        repeat (4) tick();
        repeat (3) tick();
        exp_push(S_WAIT); chk("pre_rst_wait", 32'(dbg_state));
        mon_en = 1'b1;
        reset = 1'b1;
        #1;
        exp_push(S_ALIVE); chk("async_rst_state", 32'(dbg_state));
        exp_push(3);       chk("async_rst_lives", 32'(lives));
        cycle();
        reset = 1'b0;
        repeat (10) tick();
        mon_en = 1'b0;
        exp_push(0);       chk("no_respawn", 32'(resp_seen));
        exp_push(S_ALIVE); chk("post_rst_alive", 32'(dbg_state));
        exp_push(3);       chk("post_rst_lives", 32'(lives));

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
